delay_timer: RTL and testbench
==============================

DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 28, counter and tick-value width.
REQ-002 The block SHALL provide parameter DEFAULT_TICKS, default 150000000 (3 s at 50 MHz), used when ticks==0; it SHALL fit in CNT_W bits.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, as listed below.
REQ-004 clk_50M  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 enable  input  1  level; high runs the timer, low returns it to IDLE.
REQ-007 restart  input  1  level, sampled each edge; re-arms the timer from zero.
REQ-008 pause  input  1  level; freezes counting while high.
REQ-009 mode  input  1  0 = ONESHOT, 1 = PERIODIC; latched at start/restart.
REQ-010 ticks  input  CNT_W  delay length in clock cycles; 0 selects DEFAULT_TICKS; latched at start/restart.
REQ-011 done  output  1  registered level, high while in DONE state.
REQ-012 done_pulse  output  1  registered, one cycle per completion.
REQ-013 busy  output  1  high while in RUN state.
REQ-014 remaining  output  CNT_W  target minus count in RUN, 0 otherwise.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, DONE; edge priority: rst > enable==0 > restart > pause > count.
REQ-016 An edge with enable==0 SHALL force IDLE, cnt=0, done=0, done_pulse=0, from any state.
REQ-017 IDLE, enable==1, pause==0: latch target (ticks or DEFAULT_TICKS) and mode, set cnt=1; if target==1, go to DONE per REQ-020/021, else go to RUN.
REQ-018 IDLE, enable==1, pause==1: remain IDLE, no latch.
REQ-019 RUN, pause==1, restart==0: cnt, target, outputs hold; no edge counted.
REQ-020 RUN, pause==0: if cnt+1==target the edge completes and done_pulse=1 for exactly that cycle; otherwise cnt increments.
REQ-021 ONESHOT completion: go to DONE, done=1, cnt=target; stay until enable low or restart.
REQ-022 PERIODIC completion: stay in RUN, cnt=0, done stays 0; done_pulse period equals target cycles exactly.
REQ-023 Latency: the first completion SHALL be registered on the target-th edge counting the IDLE start edge as edge 1.
REQ-024 restart==1 with enable==1 in RUN or DONE: relatch target and mode, cnt=0, go to RUN, done=0, done_pulse=0; completion falls target edges after the restart edge; pause is ignored on that edge.
REQ-025 restart==1 in IDLE SHALL act as the start condition of REQ-017 (pause still blocks).
REQ-026 pause in DONE SHALL have no effect; mode/ticks changes SHALL be ignored except at latch points.
REQ-027 The counter SHALL never exceed target and never wrap; remaining SHALL equal target-cnt in RUN.

Reset
REQ-028 rst==1 at an edge SHALL force IDLE, cnt=0, target=DEFAULT_TICKS, mode=ONESHOT, done=0, done_pulse=0, busy=0, remaining=0, regardless of other inputs, including mid-run.
REQ-029 After rst deasserts, a start SHALL require enable high on an edge per REQ-017.

Verification (CNT_W=8, DEFAULT_TICKS=5)
REQ-030 ONESHOT, ticks=0, enable rises and holds -> done and done_pulse rise on edge 5; done_pulse low at edge 6; done stays high; remaining=0.
REQ-031 PERIODIC, ticks=3 -> done_pulse at edges 3, 6, 9, 12; done never high; busy stays 1.
REQ-032 ticks=6, pause high for 2 edges after edge 2 -> completion on edge 8; remaining holds at 4 during pause.
REQ-033 ticks=4, restart pulsed on edge 3, then in DONE -> completion edge 7; restart in DONE drops done, completes 4 edges later.
REQ-034 enable dropped at edge 2, and rst asserted mid-run at another run -> next edge all outputs zero, IDLE; ticks=1 start -> done on edge 1.

Source files
------------

// File: rtl/delay_timer_if.sv
// Control/status bundle for delay_timer: start/restart/pause controls in,
// completion flags and countdown value out.
interface delay_timer_if #(
  parameter int CNT_W = 28
) ();
  logic             enable;
  logic             restart;
  logic             pause;
  logic             mode;
  logic [CNT_W-1:0] ticks;
  logic             done;
  logic             done_pulse;
  logic             busy;
  logic [CNT_W-1:0] remaining;

  modport master (
    output enable, restart, pause, mode, ticks,
    input  done, done_pulse, busy, remaining
  );

  modport slave (
    input  enable, restart, pause, mode, ticks,
    output done, done_pulse, busy, remaining
  );
endinterface

// File: rtl/delay_timer.sv
// Programmable one-shot / periodic delay timer (IDLE -> RUN -> DONE).
// Target and mode are captured only at start or restart.
module delay_timer #(
  parameter int          CNT_W         = 28,
  parameter int unsigned DEFAULT_TICKS = 150000000
) (
  input logic          clk_50M,
  input logic          rst,
  delay_timer_if.slave tmr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEF_T = DEFAULT_TICKS[CNT_W-1:0];
  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] lat_tgt;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [CNT_W-1:0] sel_target(input logic [CNT_W-1:0] t);
    return (t == '0) ? DEF_T : t;
  endfunction

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      target_q <= DEF_T;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      pulse_q  <= pulse_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    mode_d   = mode_q;
    done_d   = done_q;
    pulse_d  = 1'b0;
    lat_tgt  = sel_target(tmr.ticks);
    cnt_inc  = cnt_q + ONE;

    if (!tmr.enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (!tmr.pause) begin
            target_d = lat_tgt;
            mode_d   = tmr.mode;
            // The start edge itself counts as edge 1, so a target of 1 completes here.
            if (lat_tgt == ONE) begin
              pulse_d = 1'b1;
              if (tmr.mode) begin
                state_d = S_RUN;
                cnt_d   = '0;
              end else begin
                state_d = S_DONE;
                cnt_d   = lat_tgt;
                done_d  = 1'b1;
              end
            end else begin
              state_d = S_RUN;
              cnt_d   = ONE;
            end
          end
        end
        S_RUN, S_DONE: begin
          if (tmr.restart) begin
            target_d = lat_tgt;
            mode_d   = tmr.mode;
            cnt_d    = '0;
            state_d  = S_RUN;
            done_d   = 1'b0;
          end else if (state_q == S_RUN && !tmr.pause) begin
            if (cnt_inc == target_q) begin
              pulse_d = 1'b1;
              if (mode_q) begin
                cnt_d = '0;
              end else begin
                state_d = S_DONE;
                cnt_d   = target_q;
                done_d  = 1'b1;
              end
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign tmr.done       = done_q;
  assign tmr.done_pulse = pulse_q;
  assign tmr.busy       = (state_q == S_RUN);
  assign tmr.remaining  = (state_q == S_RUN) ? (target_q - cnt_q) : '0;

endmodule

// File: tb/tb_delay_timer.sv
// Directed bench for delay_timer with CNT_W=8, DEFAULT_TICKS=5.
module tb_delay_timer;
  localparam int CNT_W = 8;

  logic clk_50M = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  delay_timer_if #(.CNT_W(CNT_W)) tif ();

  delay_timer #(.CNT_W(CNT_W), .DEFAULT_TICKS(5)) dut (
    .clk_50M (clk_50M),
    .rst     (rst),
    .tmr     (tif)
  );

  always #10 clk_50M = ~clk_50M;

  task automatic tick();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic d, input logic p, input logic b,
                         input logic [31:0] rem);
    chk_eq({tag, "_done"},  32'(tif.done), 32'(d));
    chk_eq({tag, "_pulse"}, 32'(tif.done_pulse), 32'(p));
    chk_eq({tag, "_busy"},  32'(tif.busy), 32'(b));
    chk_eq({tag, "_rem"},   32'(tif.remaining), rem);
  endtask

  initial begin
    rst         = 1'b1;
    tif.enable  = 1'b0;
    tif.restart = 1'b0;
    tif.pause   = 1'b0;
    tif.mode    = 1'b0;
    tif.ticks   = '0;
    tick();
    tick();
    chk_all("reset", 0, 0, 0, 0);

    // One-shot with default target (5)
    rst = 1'b0;
    tif.enable = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      if (e < 5)       chk_all($sformatf("os_def_e%0d", e), 0, 0, 1, 32'(5 - e));
      else if (e == 5) chk_all("os_def_e5", 1, 1, 0, 0);
      else             chk_all("os_def_e6", 1, 0, 0, 0);
    end
    tif.enable = 1'b0;
    tick();
    chk_all("dis1", 0, 0, 0, 0);

    // Periodic, ticks=3
    tif.mode   = 1'b1;
    tif.ticks  = 8'd3;
    tif.enable = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk_all($sformatf("per_e%0d", e), 0, (e % 3) == 0, 1, 32'(3 - (e % 3)));
    end
    tif.enable = 1'b0;
    tick();
    chk_all("dis2", 0, 0, 0, 0);

    // One-shot ticks=6 with 2-edge pause after edge 2
    tif.mode   = 1'b0;
    tif.ticks  = 8'd6;
    tif.enable = 1'b1;
    tick(); chk_all("pz_e1", 0, 0, 1, 5);
    tick(); chk_all("pz_e2", 0, 0, 1, 4);
    tif.pause = 1'b1;
    tick(); chk_all("pz_e3", 0, 0, 1, 4);
    tick(); chk_all("pz_e4", 0, 0, 1, 4);
    tif.pause = 1'b0;
    tick(); chk_all("pz_e5", 0, 0, 1, 3);
    tick(); chk_all("pz_e6", 0, 0, 1, 2);
    tick(); chk_all("pz_e7", 0, 0, 1, 1);
    tick(); chk_all("pz_e8", 1, 1, 0, 0);
    tif.enable = 1'b0;
    tick();

    // ticks=4, restart on edge 3, then restart from DONE
    tif.ticks  = 8'd4;
    tif.enable = 1'b1;
    tick(); chk_all("rs_e1", 0, 0, 1, 3);
    tick(); chk_all("rs_e2", 0, 0, 1, 2);
    tif.restart = 1'b1;
    tick(); chk_all("rs_e3", 0, 0, 1, 4);
    tif.restart = 1'b0;
    tif.ticks   = 8'd7;
    tick(); chk_all("rs_e4", 0, 0, 1, 3);
    tick(); chk_all("rs_e5", 0, 0, 1, 2);
    tick(); chk_all("rs_e6", 0, 0, 1, 1);
    tick(); chk_all("rs_e7", 1, 1, 0, 0);
    tif.pause = 1'b1;
    tick(); chk_all("rs_e8", 1, 0, 0, 0);
    tif.pause   = 1'b0;
    tif.ticks   = 8'd4;
    tif.restart = 1'b1;
    tick(); chk_all("rs_e9", 0, 0, 1, 4);
    tif.restart = 1'b0;
    tick(); chk_all("rs_e10", 0, 0, 1, 3);
    tick(); chk_all("rs_e11", 0, 0, 1, 2);
    tick(); chk_all("rs_e12", 0, 0, 1, 1);
    tick(); chk_all("rs_e13", 1, 1, 0, 0);

    // Enable dropped at edge 2
    tif.enable = 1'b0;
    tick();
    tif.ticks  = 8'd5;
    tif.enable = 1'b1;
    tick(); chk_all("en_e1", 0, 0, 1, 4);
    tif.enable = 1'b0;
    tick(); chk_all("en_e2", 0, 0, 0, 0);

    // Reset mid-run, then ticks=1 start
    tif.enable = 1'b1;
    tick(); chk_all("mr_e1", 0, 0, 1, 4);
    tick(); chk_all("mr_e2", 0, 0, 1, 3);
    rst       = 1'b1;
    tif.ticks = 8'd1;
    tick(); chk_all("mr_rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick(); chk_all("t1_e1", 1, 1, 0, 0);
    tick(); chk_all("t1_e2", 1, 0, 0, 0);

    // Pause blocks start in IDLE
    tif.enable = 1'b0;
    tick();
    tif.pause  = 1'b1;
    tif.ticks  = 8'd3;
    tif.enable = 1'b1;
    tick(); chk_all("idle_pz", 0, 0, 0, 0);
    tif.pause = 1'b0;
    tick(); chk_all("idle_go", 0, 0, 1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
